// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: word width, the nop encoding, default stage geometry
// and the channel layout of the IF/ID register.
package pipe_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

    localparam int DEF_NUM_CH = 2;
    localparam int DEF_CH_W   = WORD_W;

    // Channel slots used when the stage sits between IF and ID.
    localparam int IFID_CH_IR  = 0;
    localparam int IFID_CH_PC8 = 1;

    // The encoding equals the number of held entries, so it can drive the occupancy port directly.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, a two-entry skid buffer
// (main + skid) for full throughput, and a synchronous flush that inserts a bubble.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int              NUM_CH    = DEF_NUM_CH,
    parameter int              CH_W      = DEF_CH_W,
    parameter logic [CH_W-1:0] CLEAR_VAL = CH_W'(NOP_WORD)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_CH*CH_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_CH*CH_W-1:0] out_data,
    output logic [1:0]             occupancy
);

    localparam int DATA_W = NUM_CH * CH_W;

    occ_e              state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [DATA_W-1:0] clear_word;
    logic              main_valid;
    logic              skid_valid;
    logic              accept;
    logic              drain;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_clear
        assign clear_word[k*CH_W +: CH_W] = CLEAR_VAL;
    end

    assign main_valid = (state_q != OCC_EMPTY);
    assign skid_valid = (state_q == OCC_FULL);

    // Ready depends only on registered state and flush, so there is no in->out combinational path.
    assign in_ready  = !skid_valid && !flush;
    assign accept    = in_valid && in_ready;
    assign drain     = main_valid && out_ready;

    assign out_valid = main_valid;
    assign out_data  = main_q;
    assign occupancy = state_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        unique case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (accept && drain) begin
                    main_d = in_data;
                end else if (accept) begin
                    skid_d  = in_data;
                    state_d = OCC_FULL;
                end else if (drain) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (drain) begin
                    main_d  = skid_q;
                    state_d = OCC_ONE;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase

        // Flush wins over everything; accept is already blocked through in_ready.
        if (flush) begin
            state_d = OCC_EMPTY;
            main_d  = clear_word;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= OCC_EMPTY;
            main_q  <= clear_word;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    // NOTE: the skid bank is never read while skid_valid is low, so it carries no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios on a 2x32 instance, randomised traffic on a
// 3x16 instance, both compared every cycle against a two-entry FIFO reference model.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    typedef struct {
        logic [63:0] e0;
        logic [63:0] e1;
        int          n;
        logic [63:0] shown;
    } model_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: default IF/ID geometry.
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_in_data, a_out_data;
    logic [1:0]  a_occupancy;

    // Instance B: three 16-bit channels.
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [47:0] b_in_data, b_out_data;
    logic [1:0]  b_occupancy;

    pipe_stage_skid dut_a (
        .clk(clk), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occupancy)
    );

    pipe_stage_skid #(.NUM_CH(3), .CH_W(16)) dut_b (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occupancy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit run_cmp = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: an ordered list of at most two held items; the output shows the head,
    // or the last shown item once emptied by a drain, or zero after reset/flush.
    function automatic model_t model_init();
        model_t r;
        r.e0 = '0; r.e1 = '0; r.n = 0; r.shown = '0;
        return r;
    endfunction

    function automatic model_t model_step(model_t m, logic fl, logic iv,
                                          logic [63:0] din, logic ordy);
        model_t r = m;
        bit acc, drn;
        if (fl) return model_init();
        acc = iv && (m.n < 2);
        drn = (m.n > 0) && ordy;
        if (drn) begin
            r.e0 = r.e1;
            r.n  = r.n - 1;
        end
        if (acc) begin
            if (r.n == 0) r.e0 = din;
            else          r.e1 = din;
            r.n = r.n + 1;
        end
        if (r.n > 0) r.shown = r.e0;
        return r;
    endfunction

    model_t ma, mb;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma <= model_init();
            mb <= model_init();
        end else begin
            ma <= model_step(ma, a_flush, a_in_valid, a_in_data, a_out_ready);
            mb <= model_step(mb, b_flush, b_in_valid, 64'(b_in_data), b_out_ready);
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            check("a_out_valid", 64'(a_out_valid), 64'(ma.n > 0));
            check("a_in_ready",  64'(a_in_ready),  64'((ma.n < 2) && !a_flush));
            check("a_occupancy", 64'(a_occupancy), 64'(ma.n));
            check("a_out_data",  a_out_data,       ma.shown);
            check("b_out_valid", 64'(b_out_valid), 64'(mb.n > 0));
            check("b_in_ready",  64'(b_in_ready),  64'((mb.n < 2) && !b_flush));
            check("b_occupancy", 64'(b_occupancy), 64'(mb.n));
            check("b_out_data",  64'(b_out_data),  mb.shown);
            check("b_ready_when_full", 64'(b_in_ready && (b_occupancy == 2'd2)), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ifid_word(input logic [31:0] ir, input logic [31:0] pc8);
        logic [63:0] w;
        w = '0;
        w[IFID_CH_IR*32  +: 32] = ir;
        w[IFID_CH_PC8*32 +: 32] = pc8;
        return w;
    endfunction

    initial begin
        logic [63:0] exp_w;
        bit hold;

        reset = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        #1;
        check("reset_in_ready", 64'(a_in_ready), 64'd1);
        check("reset_out_valid", 64'(a_out_valid), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        run_cmp = 1'b1;

        // Streaming: each word visible one cycle after its push, back to back.
        a_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = ifid_word(32'h2408_0001 + 32'(i), 32'h3008 + 32'(4 * i));
            tick();
            exp_w = ifid_word(32'h2408_0001 + 32'(i), 32'h3008 + 32'(4 * i));
            check("stream_data", a_out_data, exp_w);
            check("stream_valid", 64'(a_out_valid), 64'd1);
        end
        a_in_valid = 1'b0;
        tick();
        check("stream_end_valid", 64'(a_out_valid), 64'd0);

        // Asynchronous reset mid-cycle with one item held.
        a_in_valid = 1'b1;
        a_in_data  = 64'hDEAD_BEEF_0BAD_F00D;
        a_out_ready = 1'b0;
        tick();
        a_in_valid = 1'b0;
        check("pre_reset_occ", 64'(a_occupancy), 64'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(a_out_valid), 64'd0);
        check("async_rst_data",  a_out_data,       64'd0);
        check("async_rst_occ",   64'(a_occupancy), 64'd0);
        check("async_rst_ready", 64'(a_in_ready),  64'd1);
        tick();
        reset = 1'b0;
        tick();

        // Stall and skid: two items held, then drained in order.
        a_in_valid = 1'b1; a_in_data = 64'h11;
        tick();
        a_in_data = 64'h22;
        tick();
        a_in_valid = 1'b0;
        check("skid_occ_full", 64'(a_occupancy), 64'd2);
        check("skid_ready_low", 64'(a_in_ready), 64'd0);
        check("skid_head_a", a_out_data, 64'h11);
        a_out_ready = 1'b1;
        tick();
        check("skid_then_b", a_out_data, 64'h22);
        check("skid_ready_back", 64'(a_in_ready), 64'd1);
        tick();
        check("skid_drained", 64'(a_out_valid), 64'd0);

        // Flush with a full stage and a concurrent push of C.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 64'h44;
        tick();
        a_in_data = 64'h55;
        tick();
        a_flush = 1'b1; a_in_data = 64'h33;
        #1;
        check("flush_ready_low", 64'(a_in_ready), 64'd0);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("flush_valid", 64'(a_out_valid), 64'd0);
        check("flush_data",  a_out_data,       64'd0);
        check("flush_occ",   64'(a_occupancy), 64'd0);
        a_out_ready = 1'b1;
        tick();
        check("flush_c_dropped", 64'(a_out_valid), 64'd0);

        // Accept and drain in the same cycle at occupancy one.
        a_in_valid = 1'b1; a_in_data = 64'h66;
        tick();
        a_in_data = 64'h77;
        tick();
        a_in_valid = 1'b0;
        check("pass_data", a_out_data, 64'h77);
        check("pass_occ", 64'(a_occupancy), 64'd1);
        tick();

        // Randomised traffic on the 3x16 instance; a refused item is held stable.
        hold = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!hold) begin
                b_in_valid = ($urandom_range(0, 99) < 60);
                b_in_data  = 48'({$urandom(), $urandom()});
            end
            b_out_ready = ($urandom_range(0, 99) < 55);
            b_flush     = ($urandom_range(0, 99) < 3);
            @(negedge clk);
            hold = b_in_valid && !b_in_ready && !b_flush;
            tick();
        end
        b_in_valid = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
        tick();
        tick();
        check("rand_final_empty", 64'(b_occupancy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
